// File: rtl/mask_sequencer.sv
// Mask row sequencer: holds up to ROWS_MAX coding-matrix mask rows written over
// a config port and streams rows 0..n-1 over valid/ready on each start pulse.
module mask_sequencer #(
    parameter int MASK_W   = 128,
    parameter int ROWS_MAX = 16,
    localparam int ROW_AW  = $clog2(ROWS_MAX)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [ROW_AW-1:0] cfg_addr,
    input  logic [MASK_W-1:0] cfg_mask,
    input  logic [ROW_AW:0]   cfg_rows,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              cfg_err,
    output logic              mask_valid,
    input  logic              mask_ready,
    output logic [MASK_W-1:0] mask,
    output logic [ROW_AW-1:0] mask_row,
    output logic              mask_last
);
    typedef enum logic [1:0] {IDLE, ISSUE, FIN} state_t;

    localparam logic [ROW_AW:0] N_MAX = (ROW_AW+1)'(ROWS_MAX);

    state_t                           state_q, state_d;
    logic [ROWS_MAX-1:0][MASK_W-1:0]  mem_q;
    logic [ROW_AW:0]                  n_q, n_d;
    logic [ROW_AW-1:0]                row_q, row_d;
    logic [MASK_W-1:0]                mask_q, mask_d;
    logic                             last_q, last_d;
    logic                             err_q, err_d;
    logic [ROW_AW:0]                  n_start;
    logic [ROW_AW-1:0]                row_nxt;

    // Array only changes in IDLE, so rows issued during a pass are stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '0;
        end else if (cfg_we && state_q == IDLE) begin
            mem_q[cfg_addr] <= cfg_mask;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            n_q     <= '0;
            row_q   <= '0;
            mask_q  <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            row_q   <= row_d;
            mask_q  <= mask_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        row_d   = row_q;
        mask_d  = mask_q;
        last_d  = last_q;
        err_d   = err_q | (cfg_we & (state_q == ISSUE));
        n_start = (cfg_rows > N_MAX) ? N_MAX : cfg_rows;
        row_nxt = row_q + ROW_AW'(1);
        case (state_q)
            IDLE: begin
                if (start) begin
                    n_d = n_start;
                    if (n_start == '0) begin
                        state_d = FIN;
                    end else begin
                        state_d = ISSUE;
                        row_d   = '0;
                        mask_d  = mem_q[0];
                        last_d  = (n_start == (ROW_AW+1)'(1));
                    end
                end
            end
            ISSUE: begin
                if (mask_ready) begin
                    if (last_q) begin
                        state_d = FIN;
                    end else begin
                        row_d  = row_nxt;
                        mask_d = mem_q[row_nxt];
                        last_d = ({1'b0, row_q} + (ROW_AW+1)'(2)) == n_q;
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Abort wins over start and handshake; the accepted row is not re-issued.
        if (abort) state_d = IDLE;
    end

    assign busy       = (state_q == ISSUE);
    assign mask_valid = (state_q == ISSUE);
    assign done       = (state_q == FIN);
    assign cfg_err    = err_q;
    assign mask       = mask_q;
    assign mask_row   = row_q;
    assign mask_last  = last_q;
endmodule

// File: tb/tb_mask_sequencer.sv
// Directed bench for mask_sequencer; expected rows are queued at start and
// popped on each observed handshake.
module tb_mask_sequencer;
    localparam int W  = 128;
    localparam int RM = 16;
    localparam int AW = 4;

    typedef struct packed {
        logic [AW-1:0] row;
        logic [W-1:0]  mask;
        logic          last;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst, cfg_we, start, abort, mask_ready;
    logic [AW-1:0] cfg_addr;
    logic [W-1:0]  cfg_mask;
    logic [AW:0]   cfg_rows;
    logic          busy, done, cfg_err, mask_valid, mask_last;
    logic [W-1:0]  mask;
    logic [AW-1:0] mask_row;

    logic [W-1:0]  model [RM];
    exp_t          q [$];
    int            tests = 0;
    int            fails = 0;

    mask_sequencer #(.MASK_W(W), .ROWS_MAX(RM)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_mask(cfg_mask), .cfg_rows(cfg_rows), .start(start), .abort(abort),
        .busy(busy), .done(done), .cfg_err(cfg_err), .mask_valid(mask_valid),
        .mask_ready(mask_ready), .mask(mask), .mask_row(mask_row),
        .mask_last(mask_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int addr, input logic [W-1:0] data);
        cfg_we = 1'b1; cfg_addr = AW'(addr); cfg_mask = data;
        model[addr] = data;
        step();
        cfg_we = 1'b0;
    endtask

    // mode 0: ready always high; mode 1: ready 1,0,0 repeating.
    // wr_cyc: pass cycle with an illegal write to row 1; abort_after: row after which to abort.
    task automatic pass(input int cfg, input int mode, input int wr_cyc, input int abort_after);
        int          n;
        exp_t        e;
        bit          fin, aborted, stall;
        logic [W-1:0]  pm;
        logic [AW-1:0] pr;
        n = (cfg > RM) ? RM : cfg;
        for (int i = 0; i < n; i++) q.push_back({AW'(i), model[i], (i == n-1)});
        cfg_rows = (AW+1)'(cfg);
        start = 1'b1;
        step();
        start = 1'b0;
        if (n == 0) begin
            @(negedge clk);
            chk("n0_done", 128'(done), 128'(1));
            chk("n0_valid", 128'(mask_valid), 128'(0));
            step();
            return;
        end
        fin = 0; aborted = 0; stall = 0; pm = '0; pr = '0;
        for (int c = 0; c < 300 && !fin; c++) begin
            mask_ready = (mode == 0) || (c % 3 == 0);
            if (c == wr_cyc) begin
                cfg_we = 1'b1; cfg_addr = 4'd1; cfg_mask = 128'hDEAD_BEEF;
            end else cfg_we = 1'b0;
            @(negedge clk);
            if (c == 0) chk("first_valid", 128'(mask_valid), 128'(1));
            if (stall) begin
                chk("stall_mask", mask, pm);
                chk("stall_row", 128'(mask_row), 128'(pr));
            end
            stall = mask_valid && !mask_ready;
            pm = mask; pr = mask_row;
            if (mask_valid && mask_ready) begin
                if (q.size() == 0) begin
                    chk("extra_row", 128'(mask_row), 128'(RM));
                    fin = 1;
                end else begin
                    e = q.pop_front();
                    chk("row", 128'(mask_row), 128'(e.row));
                    chk("mask", mask, e.mask);
                    chk("last", 128'(mask_last), 128'(e.last));
                    if (abort_after >= 0 && int'(e.row) == abort_after) begin
                        step();
                        abort = 1'b1; mask_ready = 1'b0; cfg_we = 1'b0;
                        step();
                        abort = 1'b0;
                        @(negedge clk);
                        chk("abort_valid", 128'(mask_valid), 128'(0));
                        chk("abort_busy", 128'(busy), 128'(0));
                        chk("abort_done", 128'(done), 128'(0));
                        q.delete();
                        aborted = 1;
                        fin = 1;
                    end else if (q.size() == 0) fin = 1;
                end
            end
            step();
        end
        cfg_we = 1'b0;
        if (!fin) begin
            chk("timeout", 128'(0), 128'(1));
            q.delete();
        end else if (aborted) begin
            @(negedge clk);
            chk("abort_nodone", 128'(done), 128'(0));
        end else begin
            @(negedge clk);
            chk("done", 128'(done), 128'(1));
            chk("done_valid", 128'(mask_valid), 128'(0));
            chk("done_busy", 128'(busy), 128'(0));
            step();
            @(negedge clk);
            chk("done_pulse", 128'(done), 128'(0));
        end
    endtask

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_mask = '0; cfg_rows = '0;
        start = 1'b0; abort = 1'b0; mask_ready = 1'b1;
        for (int i = 0; i < RM; i++) model[i] = '0;
        #12;
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_err", 128'(cfg_err), 128'(0));
        chk("rst_valid", 128'(mask_valid), 128'(0));
        chk("rst_mask", mask, 128'(0));
        chk("rst_row", 128'(mask_row), 128'(0));
        chk("rst_last", 128'(mask_last), 128'(0));
        step();
        rst = 1'b0;
        step();

        wr(0, 128'h1); wr(1, 128'h3); wr(2, 128'h7); wr(3, 128'hF);
        pass(4, 0, -1, -1);
        pass(4, 1, -1, -1);
        pass(0, 0, -1, -1);

        for (int i = 4; i < RM; i++) wr(i, {$urandom, $urandom, $urandom, $urandom});
        pass(RM + 5, 0, -1, -1);
        pass(RM, 1, -1, -1);

        chk("err_before", 128'(cfg_err), 128'(0));
        pass(4, 0, 1, -1);
        chk("err_set", 128'(cfg_err), 128'(1));
        pass(2, 0, -1, -1);
        chk("err_sticky", 128'(cfg_err), 128'(1));

        pass(8, 0, -1, 2);
        pass(4, 0, -1, -1);

        cfg_rows = 5'd4; mask_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("pre_rst_valid", 128'(mask_valid), 128'(1));
        rst = 1'b1;
        #2;
        chk("arst_valid", 128'(mask_valid), 128'(0));
        chk("arst_busy", 128'(busy), 128'(0));
        chk("arst_mask", mask, 128'(0));
        chk("arst_row", 128'(mask_row), 128'(0));
        chk("arst_last", 128'(mask_last), 128'(0));
        chk("arst_err", 128'(cfg_err), 128'(0));
        chk("arst_done", 128'(done), 128'(0));
        step();
        rst = 1'b0;
        for (int i = 0; i < RM; i++) model[i] = '0;
        step();
        pass(2, 0, -1, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mask_sequencer.md
# mask_sequencer

Control block that stores the coding-matrix mask rows and issues them one per handshake to the mask unit that gates packet lanes before XOR reduction. Software writes up to ROWS_MAX mask rows through a config port, then a start pulse makes the block stream rows 0..N-1 over a valid/ready interface. It sits between the accelerator's configuration path and the engine's mask datapath and signals completion of each coding pass.

## Interface
- MASK_W, 128, width of one mask row (one bit per packet lane)
- ROWS_MAX, 16, number of mask rows stored; power of two, >= 2
- ROW_AW, $clog2(ROWS_MAX), local, row index width (not overridable)

- clk  input  1  clock; all logic on rising edge
- rst  input  1  reset, asynchronous, active-high
- cfg_we  input  1  write one mask row
- cfg_addr  input  ROW_AW  row index to write
- cfg_mask  input  MASK_W  row data
- cfg_rows  input  ROW_AW+1  number of rows for the next pass, sampled at start
- start  input  1  single-cycle pulse, begin a pass
- abort  input  1  terminate the current pass
- busy  output  1  pass in progress
- done  output  1  one-cycle pulse, pass completed normally
- cfg_err  output  1  sticky; write attempted while busy
- mask_valid  output  1  mask/mask_row/mask_last valid
- mask_ready  input  1  downstream accepts
- mask  output  MASK_W  current mask row
- mask_row  output  ROW_AW  index of current row
- mask_last  output  1  current row is the final row of the pass

## Operation
- Storage: ROWS_MAX x MASK_W register array, cleared to 0 on rst.
- Writes: cfg_we in IDLE writes cfg_mask to row cfg_addr; visible from the next cycle. cfg_we while busy is dropped and sets cfg_err; cfg_err clears only on rst.
- States: IDLE, ISSUE, FIN.
- IDLE: busy=0, mask_valid=0. start latches n = min(cfg_rows, ROWS_MAX). n==0 -> FIN (no rows issued). n>0 -> ISSUE with row counter 0.
- ISSUE: busy=1, mask_valid=1, mask=array[row], mask_row=row, mask_last=(row==n-1). On mask_valid&mask_ready: if last -> FIN, else row+1. Without ready, all outputs hold stable.
- FIN: done=1 for exactly one cycle, busy=0, then IDLE.
- abort (any state) -> IDLE next cycle, mask_valid drops, no done pulse. abort has priority over start and over a same-cycle handshake (handshake on that cycle still counts as accepted by downstream, but no further rows issue).
- start while busy is ignored. start and cfg_we in the same IDLE cycle: write is performed and start samples the pre-write array contents for row 0 only if row 0 is the written row (array read is registered; see Timing).
- Counter never wraps: n <= ROWS_MAX, counter stops at n-1.

## Timing
- Reset values: busy=0, done=0, cfg_err=0, mask_valid=0, mask=0, mask_row=0, mask_last=0; state IDLE.
- mask, mask_row, mask_last are registered outputs.
- start at cycle t -> mask_valid=1 with row 0 at t+1.
- Throughput: one row per cycle with mask_ready held high; n rows occupy cycles t+1..t+n.
- Last handshake at cycle c -> done=1 at c+1, mask_valid=0 at c+1; start accepted again from c+2.
- n==0: start at t -> done=1 at t+1, mask_valid never asserts.
- abort at cycle a -> mask_valid=0, busy=0 at a+1.
- rst asserted mid-pass: outputs return to reset values immediately (asynchronous); array contents cleared.

## Test plan
- Write rows 0..3 with 0x1, 0x3, 0x7, 0xF, cfg_rows=4, start, ready high -> masks 0x1,0x3,0x7,0xF on 4 consecutive cycles, mask_last only on row 3, done 1 cycle after.
- Same pass, mask_ready toggled 1,0,0,1,... -> mask/mask_row stable during stalls, every row issued exactly once in order, no duplicates.
- cfg_rows=0 start -> done at t+1, no mask_valid; cfg_rows=ROWS_MAX+5 -> exactly ROWS_MAX rows issued.
- cfg_we during ISSUE to row 1 -> row 1 issues old value, cfg_err=1 and stays 1 until rst.
- abort after row 2 accepted in 8-row pass -> mask_valid=0 next cycle, no done, new start issues from row 0.
- rst asserted during ISSUE -> all outputs 0 without clock edge; subsequent pass with cfg_rows=2 issues two all-zero masks.
